periph_bus_arbiter: RTL
=======================

Name: periph_bus_arbiter

Overview:
Shares the single Peripheral register bus (rd/wr/addr/wdata/rdata) between two masters.
- Master 0: the CPU data port.
- Master 1: a secondary requester, e.g. UART loader or debug port.
- Serialises accesses through a 3-state FSM, with fixed or round-robin priority, anti-starvation aging and a master-0 bus lock for read-modify-write.
- Sits in the system top between the CPU/loader and the Peripheral instance.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
CPU_PRIO, 1, 1 = master 0 fixed priority; 0 = round-robin
MAX_WAIT, 4, master-0 grants tolerated while m1_req is pending before m1 is forced (CPU_PRIO=1 only); range 1..15

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 transaction request, held until m0_ack
m0_wr  in  1  1 = write, 0 = read
m0_lock  in  1  keep bus owned by m0 after this transaction
m0_addr  in  ADDR_W  address
m0_wdata  in  DATA_W  write data
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  DATA_W  read data, valid while m0_ack
m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0 (no lock)
s_rd  out  1  Peripheral read strobe
s_wr  out  1  Peripheral write strobe
s_addr  out  ADDR_W  Peripheral address
s_wdata  out  DATA_W  Peripheral write data
s_rdata  in  DATA_W  Peripheral read data, combinational from s_addr
owner  out  1  index of the current/last granted master
busy  out  1  high in ISSUE and DONE

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; owner=0; locked=0; wait_cnt=0; rr_last=1 (m0 wins first RR tie).
- FSM IDLE -> ISSUE -> DONE -> IDLE.
  - IDLE: sample m0_req/m1_req. If neither is high, stay. Otherwise pick a winner, latch its wr/addr/wdata, and latch lock (m0 only). Set owner and go to ISSUE.
  - ISSUE: drive s_addr/s_wdata from latches and assert exactly one of s_rd/s_wr for this single cycle. If read, register s_rdata at the end of the cycle. Go to DONE.
  - DONE: assert the winner's mX_ack for 1 cycle; mX_rdata = captured data (0 for writes). Go to IDLE.
- Latency: req high in IDLE at cycle N -> strobe at N+1 -> ack at N+2. Back-to-back throughput is one transaction per 3 cycles.
- Requests are sampled only in IDLE. A req still high in the IDLE cycle after ack is a new transaction, so masters drop req on the edge that ends their ack cycle.
- Winner selection, in priority order:
  1. locked=1: only m0 is considered; m1 waits regardless of aging.
  2. CPU_PRIO=1: m1 wins if wait_cnt==MAX_WAIT and m1_req; otherwise m0 wins if m0_req, else m1.
  3. CPU_PRIO=0: on a tie, the master other than rr_last wins; rr_last updates on every grant.
- wait_cnt rules (all applied at grant time; they are mutually exclusive):
  - Increments, saturating at MAX_WAIT, on each m0 grant while m1_req=1.
  - Clears on an m1 grant.
  - Clears on an m0 grant when m1_req=0.
  - Unused when CPU_PRIO=0.
- locked is set at an m0 grant with m0_lock=1 and cleared at an m0 grant with m0_lock=0. A locked bus with m0_req low simply idles.
- s_rd and s_wr are never both high. Both are 0 outside ISSUE. s_addr/s_wdata hold their last values outside ISSUE.
- Reset mid-transaction: immediate return to IDLE with strobes low. An ack in flight is lost and must not be issued after reset.
- No address decoding or range checks; all addresses are passed through.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, DONE=2'd2), master index constants M_CPU=0 and M_AUX=1.
- One combinational sub-module, periph_arb_pick, holds the winner selection. Inputs: reqs, locked, wait_cnt, rr_last, CPU_PRIO, MAX_WAIT. Output: grant index.

Test Plan:
1. m0 read of 0x40000014, s_rdata=0x0000_00A5 -> s_rd high exactly cycle N+1; m0_ack with m0_rdata=0xA5 at N+2; m1_ack stays 0.
2. CPU_PRIO=1, m0 and m1 both request every IDLE -> four m0 grants, then m1 granted on the 5th; wait_cnt returns to 0.
3. CPU_PRIO=0, both requesting continuously -> grants alternate m0, m1, m0, m1 with owner toggling; one ack per 3 cycles.
4. m0 write 0x40000000 <- 0x1 with lock=1, then m0 read with lock=0, while m1_req is held throughout -> m1 is not granted until after the unlocked m0 ack.
5. m1 write in flight, reset low during ISSUE -> s_wr drops asynchronously; no m1_ack appears after reset release; owner=0.
6. Write -> s_wr pulse of 1 cycle, s_wdata matches the master's value, m0_rdata=0, and s_rd stays 0 throughout.

Source files
------------

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter.
package periph_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/periph_bus_arbiter_pick.sv
// Winner selection between the CPU and auxiliary masters; only meaningful when a request is present.
module periph_arb_pick
    import periph_bus_arbiter_pkg::*;
#(
    parameter int CPU_PRIO = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic [1:0] reqs,
    input  logic       locked,
    input  logic [3:0] wait_cnt,
    input  logic       rr_last,
    output logic       grant
);

    always_comb begin
        grant = M_CPU;
        if (locked) begin
            grant = M_CPU;
        end else if (CPU_PRIO != 0) begin
            // Aging overrides CPU priority once the aux master has waited long enough.
            if (reqs[M_AUX] && wait_cnt == 4'(MAX_WAIT)) grant = M_AUX;
            else if (reqs[M_CPU])                         grant = M_CPU;
            else                                          grant = M_AUX;
        end else begin
            if (&reqs)              grant = ~rr_last;
            else if (reqs[M_CPU])   grant = M_CPU;
            else                    grant = M_AUX;
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Serialises CPU and auxiliary master accesses onto the single peripheral register bus.
module periph_bus_arbiter
    import periph_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int CPU_PRIO = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_rd,
    output logic              s_wr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              owner,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              locked_q, locked_d;
    logic [3:0]        wait_q, wait_d;
    logic              rr_last_q, rr_last_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt;
    logic              any_req;

    periph_arb_pick #(
        .CPU_PRIO (CPU_PRIO),
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .reqs     ({m1_req, m0_req}),
        .locked   (locked_q),
        .wait_cnt (wait_q),
        .rr_last  (rr_last_q),
        .grant    (gnt)
    );

    // While locked, a pending aux request alone must not start a transaction.
    assign any_req = locked_q ? m0_req : (m0_req | m1_req);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        locked_d  = locked_q;
        wait_d    = wait_q;
        rr_last_d = rr_last_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = ISSUE;
                    owner_d   = gnt;
                    rr_last_d = gnt;
                    if (gnt == M_CPU) begin
                        wr_d     = m0_wr;
                        addr_d   = m0_addr;
                        wdata_d  = m0_wdata;
                        locked_d = m0_lock;
                        if (CPU_PRIO != 0) begin
                            if (!m1_req)                       wait_d = '0;
                            else if (wait_q != 4'(MAX_WAIT))   wait_d = wait_q + 4'd1;
                        end
                    end else begin
                        wr_d    = m1_wr;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        wait_d  = '0;
                    end
                end
            end
            ISSUE: begin
                rdata_d = wr_q ? '0 : s_rdata;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= M_CPU;
            locked_q  <= 1'b0;
            wait_q    <= '0;
            rr_last_q <= M_AUX;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            locked_q  <= locked_d;
            wait_q    <= wait_d;
            rr_last_q <= rr_last_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_rd     = (state_q == ISSUE) && !wr_q;
    assign s_wr     = (state_q == ISSUE) && wr_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign m0_ack   = (state_q == DONE) && (owner_q == M_CPU);
    assign m1_ack   = (state_q == DONE) && (owner_q == M_AUX);
    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;
    assign owner    = owner_q;
    assign busy     = (state_q == ISSUE) || (state_q == DONE);

endmodule
